mux_arbiter: RTL

- Two-requester round-robin arbiter that owns the select line of the team's 2:1 channel mux.
- Grants one requester at a time and drives the mux select to match the grant.
- Enforces a maximum hold time when the other side is waiting.
- Inserts a guard gap between grants so the mux output never switches while a consumer is still sampling.

---
 rtl/mux_arbiter_if.sv | 27 ++
 rtl/mux_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mux_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arbiter_if
//  Description : Request/grant/select bundle between the mux arbiter and the
//                two channels whose traffic shares the 2:1 mux.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux_arbiter_if;
  logic req_1;
  logic req_2;
  logic gnt_1;
  logic gnt_2;
  logic sel;
  logic busy;
  logic hold_expired;

  modport master (
    output req_1, req_2,
    input  gnt_1, gnt_2, sel, busy, hold_expired
  );

  modport slave (
    input  req_1, req_2,
    output gnt_1, gnt_2, sel, busy, hold_expired
  );
endinterface
`default_nettype wire

// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arbiter
//  Description : Two-requester round-robin arbiter owning the 2:1 mux select,
//                with a bounded hold time and a guard gap between grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_arbiter #(
  parameter int MAX_HOLD   = 255,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 8
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  mux_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT1 = 2'd1,
    ST_GRANT2 = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  localparam logic             c_hold_en   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] c_hold_last = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

  state_t           r_state;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] r_gap_cnt;
  logic             r_last_ch1;
  logic             r_gnt_1;
  logic             r_gnt_2;
  logic             r_sel;
  logic             r_busy;
  logic             r_hold_expired;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;
  logic [CNT_W-1:0] w_gap_cnt_nxt;
  logic             w_last_nxt;
  logic             w_expire;
  logic             w_arbitrate;
  logic             w_pick_ch1;
  logic             w_sel_nxt;

  // Ties go to the channel that was not served last.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_last_nxt     = r_last_ch1;
    w_expire       = 1'b0;
    w_arbitrate    = 1'b0;
    w_pick_ch1     = bus.req_1 & (~bus.req_2 | ~r_last_ch1);

    case (r_state)
      ST_IDLE: w_arbitrate = 1'b1;
      ST_GRANT1: begin
        if (r_hold_cnt != c_cnt_max) w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        if (!bus.req_1) begin
          w_state_nxt   = ST_GAP;
          w_gap_cnt_nxt = '0;
        end else if (c_hold_en && (r_hold_cnt == c_hold_last) && bus.req_2) begin
          w_state_nxt   = ST_GAP;
          w_gap_cnt_nxt = '0;
          w_expire      = 1'b1;
        end
      end
      ST_GRANT2: begin
        if (r_hold_cnt != c_cnt_max) w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        if (!bus.req_2) begin
          w_state_nxt   = ST_GAP;
          w_gap_cnt_nxt = '0;
        end else if (c_hold_en && (r_hold_cnt == c_hold_last) && bus.req_1) begin
          w_state_nxt   = ST_GAP;
          w_gap_cnt_nxt = '0;
          w_expire      = 1'b1;
        end
      end
      ST_GAP: begin
        // Last gap cycle arbitrates directly so the waiter sees no idle bubble.
        if (r_gap_cnt == c_gap_last) begin
          w_state_nxt = ST_IDLE;
          w_arbitrate = 1'b1;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_arbitrate && (bus.req_1 || bus.req_2)) begin
      w_state_nxt    = w_pick_ch1 ? ST_GRANT1 : ST_GRANT2;
      w_hold_cnt_nxt = '0;
      w_last_nxt     = w_pick_ch1;
    end

    w_sel_nxt = r_sel;
    if (w_state_nxt == ST_GRANT1) w_sel_nxt = 1'b1;
    else if (w_state_nxt == ST_GRANT2) w_sel_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_hold_cnt     <= '0;
      r_gap_cnt      <= '0;
      r_last_ch1     <= 1'b0;
      r_gnt_1        <= 1'b0;
      r_gnt_2        <= 1'b0;
      r_sel          <= 1'b0;
      r_busy         <= 1'b0;
      r_hold_expired <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_hold_cnt     <= w_hold_cnt_nxt;
      r_gap_cnt      <= w_gap_cnt_nxt;
      r_last_ch1     <= w_last_nxt;
      r_gnt_1        <= (w_state_nxt == ST_GRANT1);
      r_gnt_2        <= (w_state_nxt == ST_GRANT2);
      r_sel          <= w_sel_nxt;
      r_busy         <= (w_state_nxt != ST_IDLE);
      r_hold_expired <= w_expire;
    end
  end

  assign bus.gnt_1        = r_gnt_1;
  assign bus.gnt_2        = r_gnt_2;
  assign bus.sel          = r_sel;
  assign bus.busy         = r_busy;
  assign bus.hold_expired = r_hold_expired;

  a_gnt_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !(r_gnt_1 && r_gnt_2));
  a_sel_gnt_1 : assert property (@(posedge clk) disable iff (!rst_n)
    r_gnt_1 |-> r_sel);
  a_sel_gnt_2 : assert property (@(posedge clk) disable iff (!rst_n)
    r_gnt_2 |-> !r_sel);
  a_sel_on_entry : assert property (@(posedge clk) disable iff (!rst_n)
    !$stable(r_sel) |-> ($rose(r_gnt_1) || $rose(r_gnt_2)));

endmodule
`default_nettype wire
